dma_protocol_monitor: RTL and testbench



---
 rtl/dma_protocol_monitor_if.sv | 22 ++
 rtl/dma_protocol_monitor.sv | 170 +++++++++++++++++
 tb/tb_dma_protocol_monitor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dma_protocol_monitor_if.sv
// DMA bus signals observed by the protocol monitor.
// The controller/testbench drives through master; the monitor only listens through slave.
interface dma_protocol_monitor_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] DACK;
  logic              HRQ;
  logic              HLDA;
  logic              AEN;
  logic              ADSTB;
  logic              IOR_N;
  logic              IOW_N;
  logic              MEMR_N;
  logic              MEMW_N;
  logic              EOP_N;

  modport master (output DREQ, DACK, HRQ, HLDA, AEN, ADSTB,
                  IOR_N, IOW_N, MEMR_N, MEMW_N, EOP_N);
  modport slave  (input  DREQ, DACK, HRQ, HLDA, AEN, ADSTB,
                  IOR_N, IOW_N, MEMR_N, MEMW_N, EOP_N);
endinterface

// File: rtl/dma_protocol_monitor.sv
// Passive DMA bus monitor: tracks each service cycle, flags handshake/priority/strobe
// violations as sticky bits and keeps saturating per-channel transfer counts.
module dma_protocol_monitor #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int HLDA_TIMEOUT = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  dma_protocol_monitor_if.slave   bus,
  input  logic                    PRIO_ROTATE,
  input  logic                    CLR_ERR,
  output logic [7:0]              ERR_FLAGS,
  output logic                    ERR_VALID,
  output logic [2:0]              ERR_CODE,
  output logic [NUM_CH*CNT_W-1:0] XFER_COUNT,
  output logic [2:0]              MON_STATE
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TMR_W = $clog2(HLDA_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT = 3'd1, S_ADDR = 3'd2, S_XFER = 3'd3, S_END = 3'd4
  } state_e;

  state_e                        state_q;
  logic [TMR_W-1:0]              timer_q;
  logic [CH_W-1:0]               last_q;
  logic [NUM_CH-1:0]             exp_q, gnt_q;
  logic                          seen_q, adstb_q, valid_q;
  logic [7:0]                    flags_q;
  logic [2:0]                    code_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q;

  function automatic logic [NUM_CH-1:0] fixed_win(input logic [NUM_CH-1:0] r);
    logic [NUM_CH-1:0] w;
    w = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (r[CH_W'(i)]) begin
        w = '0;
        w[CH_W'(i)] = 1'b1;
      end
    return w;
  endfunction

  // Scan downward over offsets so the nearest channel after last-serviced wins.
  function automatic logic [NUM_CH-1:0] rot_win(input logic [NUM_CH-1:0] r,
                                                input logic [CH_W-1:0] last);
    logic [NUM_CH-1:0] w;
    int idx;
    w = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_CH;
      if (r[CH_W'(idx)]) begin
        w = '0;
        w[CH_W'(idx)] = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [CH_W-1:0] lo_idx(input logic [NUM_CH-1:0] v);
    logic [CH_W-1:0] x;
    x = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (v[CH_W'(i)]) x = CH_W'(i);
    return x;
  endfunction

  logic [NUM_CH-1:0] win_d, cnt_vec_d;
  logic [CH_W-1:0]   cnt_idx_d;
  logic [7:0]        err_d, flags_d;
  logic [2:0]        code_d;
  logic              eop_d, str_low_d, cnt_en_d, in_cycle_d;

  always_comb begin
    win_d      = PRIO_ROTATE ? rot_win(bus.DREQ, last_q) : fixed_win(bus.DREQ);
    str_low_d  = ~bus.IOR_N | ~bus.IOW_N | ~bus.MEMR_N | ~bus.MEMW_N;
    in_cycle_d = (state_q == S_ADDR) || (state_q == S_XFER) || (state_q == S_END);
    eop_d      = in_cycle_d && !bus.EOP_N;
    // In ADDR the grant is not latched yet, so an early EOP counts the live DACK.
    cnt_vec_d  = (state_q == S_ADDR) ? bus.DACK : gnt_q;
    cnt_idx_d  = lo_idx(cnt_vec_d);
    cnt_en_d   = ((state_q == S_END) || eop_d) && (|cnt_vec_d);

    err_d    = '0;
    err_d[0] = |(bus.DACK & (bus.DACK - 1'b1));
    err_d[1] = !bus.IOR_N && !bus.IOW_N;
    err_d[2] = !bus.MEMR_N && !bus.MEMW_N;
    err_d[3] = bus.ADSTB && adstb_q;
    err_d[4] = (state_q == S_ADDR) && !bus.AEN;
    err_d[5] = (state_q == S_WAIT) && bus.HRQ && !bus.HLDA &&
               (timer_q == TMR_W'(HLDA_TIMEOUT - 1));
    err_d[6] = (state_q == S_ADDR) && (|exp_q) && (bus.DACK != exp_q);
    err_d[7] = (|bus.DACK) && !bus.HLDA;

    flags_d = (CLR_ERR ? 8'h00 : flags_q) | err_d;
    code_d  = code_q;
    for (int i = 7; i >= 0; i--)
      if (err_d[3'(i)]) code_d = 3'(i);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      exp_q   <= '0;
      gnt_q   <= '0;
      seen_q  <= 1'b0;
      adstb_q <= 1'b0;
      valid_q <= 1'b0;
      flags_q <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      adstb_q <= bus.ADSTB;
      flags_q <= flags_d;
      valid_q <= |err_d;
      code_q  <= code_d;
      if (cnt_en_d) begin
        if (cnt_q[cnt_idx_d] != '1) cnt_q[cnt_idx_d] <= cnt_q[cnt_idx_d] + 1'b1;
        last_q <= cnt_idx_d;
      end
      unique case (state_q)
        S_IDLE:
          if (bus.HRQ) begin
            state_q <= S_WAIT;
            timer_q <= '0;
          end
        S_WAIT:
          if (bus.HLDA) begin
            exp_q   <= win_d;
            state_q <= S_ADDR;
          end else if (!bus.HRQ) begin
            state_q <= S_IDLE;
          end else if (timer_q != TMR_W'(HLDA_TIMEOUT)) begin
            timer_q <= timer_q + 1'b1;
          end
        S_ADDR: begin
          gnt_q   <= bus.DACK;
          seen_q  <= 1'b0;
          state_q <= eop_d ? S_IDLE : S_XFER;
        end
        S_XFER:
          if (eop_d) begin
            state_q <= S_IDLE;
          end else begin
            seen_q <= seen_q | str_low_d;
            if (seen_q && !str_low_d) state_q <= S_END;
          end
        S_END:
          // Demand/block mode: controller keeps the same DACK and HRQ for another beat.
          if (!eop_d && bus.HRQ && (bus.DACK == gnt_q)) begin
            exp_q   <= gnt_q;
            state_q <= S_ADDR;
          end else begin
            state_q <= S_IDLE;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ERR_FLAGS  = flags_q;
  assign ERR_VALID  = valid_q;
  assign ERR_CODE   = code_q;
  assign XFER_COUNT = cnt_q;
  assign MON_STATE  = state_q;
endmodule

// File: tb/tb_dma_protocol_monitor.sv
// Directed bench for dma_protocol_monitor: expectations queued as each scenario is
// driven, then popped and compared against the registered outputs.
module tb_dma_protocol_monitor;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int TMO = 16;

  logic              CLK = 1'b0;
  logic              RESET, PRIO_ROTATE, CLR_ERR;
  logic [7:0]        ERR_FLAGS;
  logic              ERR_VALID;
  logic [2:0]        ERR_CODE;
  logic [NCH*CW-1:0] XFER_COUNT;
  logic [2:0]        MON_STATE;

  dma_protocol_monitor_if #(.NUM_CH(NCH)) bus ();

  dma_protocol_monitor #(.NUM_CH(NCH), .CNT_W(CW), .HLDA_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .PRIO_ROTATE(PRIO_ROTATE), .CLR_ERR(CLR_ERR),
    .ERR_FLAGS(ERR_FLAGS), .ERR_VALID(ERR_VALID), .ERR_CODE(ERR_CODE),
    .XFER_COUNT(XFER_COUNT), .MON_STATE(MON_STATE)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0, ev_cnt = 0;

  // ERR_VALID pulses counted on the falling edge, away from the update edge.
  always @(negedge CLK) if (ERR_VALID === 1'b1) ev_cnt++;

  typedef struct { string tag; logic [15:0] exp; } exp_t;
  exp_t sb[$];

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic expect_v(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (obs === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [15:0] cnt(input int ch);
    return 16'(XFER_COUNT[ch*CW +: CW]);
  endfunction

  task automatic idle_bus;
    bus.DREQ = '0; bus.DACK = '0; bus.HRQ = 1'b0; bus.HLDA = 1'b0;
    bus.AEN = 1'b0; bus.ADSTB = 1'b0; bus.IOR_N = 1'b1; bus.IOW_N = 1'b1;
    bus.MEMR_N = 1'b1; bus.MEMW_N = 1'b1; bus.EOP_N = 1'b1;
  endtask

  task automatic do_reset;
    RESET = 1'b1; tick; RESET = 1'b0; ev_cnt = 0;
  endtask

  task automatic do_clr;
    CLR_ERR = 1'b1; tick; CLR_ERR = 1'b0; ev_cnt = 0;
  endtask

  // From WAIT_HLDA: grant, one address cycle, one MEMR/IOW strobe pulse, END.
  task automatic tail(input logic [NCH-1:0] dack);
    bus.HLDA = 1'b1; tick;
    bus.AEN = 1'b1; bus.ADSTB = 1'b1; bus.DACK = dack; tick;
    bus.ADSTB = 1'b0; bus.MEMR_N = 1'b0; bus.IOW_N = 1'b0; tick;
    bus.MEMR_N = 1'b1; bus.IOW_N = 1'b1; tick;
    bus.HRQ = 1'b0; bus.DREQ = '0; tick;
    idle_bus;
  endtask

  task automatic svc(input logic [NCH-1:0] dreq, input logic [NCH-1:0] dack, input int dly);
    bus.DREQ = dreq; bus.HRQ = 1'b1; tick;
    repeat (dly) tick;
    tail(dack);
  endtask

  initial begin
    RESET = 1'b1; PRIO_ROTATE = 1'b0; CLR_ERR = 1'b0;
    idle_bus;
    tick; tick;
    expect_v("rst_flags", 16'h00); expect_v("rst_valid", 16'h0); expect_v("rst_code", 16'h0);
    expect_v("rst_count", 16'h0);  expect_v("rst_state", 16'h0);
    check(16'(ERR_FLAGS)); check(16'(ERR_VALID)); check(16'(ERR_CODE));
    check(XFER_COUNT); check(16'(MON_STATE));
    RESET = 1'b0; tick; ev_cnt = 0;

    // Clean fixed-priority cycle
    expect_v("clean_flags", 16'h00); expect_v("clean_ch1", 16'd1);
    expect_v("clean_state", 16'd0);  expect_v("clean_pulses", 16'd0);
    svc(4'b0110, 4'b0010, 3);
    check(16'(ERR_FLAGS)); check(cnt(1)); check(16'(MON_STATE)); check(16'(ev_cnt));

    // Priority violation, transfer still counted on the acknowledged channel
    do_clr;
    expect_v("prio_flags", 16'h40); expect_v("prio_code", 16'd6);
    expect_v("prio_pulses", 16'd1); expect_v("prio_ch2", 16'd1);
    svc(4'b0110, 4'b0100, 3);
    check(16'(ERR_FLAGS)); check(16'(ERR_CODE)); check(16'(ev_cnt)); check(cnt(2));

    // Rotating priority
    do_reset; PRIO_ROTATE = 1'b1;
    svc(4'b0001, 4'b0001, 0);
    expect_v("rot_ok_flags", 16'h00); expect_v("rot_ok_ch1", 16'd1);
    svc(4'b0011, 4'b0010, 0);
    check(16'(ERR_FLAGS)); check(cnt(1));
    svc(4'b0001, 4'b0001, 0);
    expect_v("rot_bad_flags", 16'h40); expect_v("rot_bad_code", 16'd6); expect_v("rot_ch0", 16'd3);
    svc(4'b0011, 4'b0001, 0);
    check(16'(ERR_FLAGS)); check(16'(ERR_CODE)); check(cnt(0));
    PRIO_ROTATE = 1'b0;

    // HLDA timeout: quiet at TMO-1 waiting cycles, raised on the TMO-th, only once
    do_reset;
    bus.DREQ = 4'b0001; bus.HRQ = 1'b1; tick;
    repeat (TMO - 1) tick;
    expect_v("tmo_early_flags", 16'h00); expect_v("tmo_state", 16'd1);
    check(16'(ERR_FLAGS)); check(16'(MON_STATE));
    tick;
    expect_v("tmo_flags", 16'h20); expect_v("tmo_code", 16'd5); expect_v("tmo_valid", 16'd1);
    check(16'(ERR_FLAGS)); check(16'(ERR_CODE)); check(16'(ERR_VALID));
    repeat (5) tick;
    expect_v("tmo_once", 16'd1);
    check(16'(ev_cnt));
    expect_v("tmo_done_flags", 16'h20); expect_v("tmo_done_ch0", 16'd1); expect_v("tmo_done_state", 16'd0);
    tail(4'b0001);
    check(16'(ERR_FLAGS)); check(cnt(0)); check(16'(MON_STATE));

    // Simultaneous faults, then clear racing a new ADSTB violation
    do_clr;
    bus.HLDA = 1'b1; bus.IOR_N = 1'b0; bus.IOW_N = 1'b0; bus.DACK = 4'b0011; tick;
    expect_v("multi_flags", 16'h03); expect_v("multi_code", 16'd0); expect_v("multi_valid", 16'd1);
    check(16'(ERR_FLAGS)); check(16'(ERR_CODE)); check(16'(ERR_VALID));
    idle_bus; tick;
    expect_v("multi_valid_drop", 16'd0);
    check(16'(ERR_VALID));
    bus.ADSTB = 1'b1; tick;
    CLR_ERR = 1'b1; tick;
    CLR_ERR = 1'b0; bus.ADSTB = 1'b0;
    expect_v("clr_adstb_flags", 16'h08); expect_v("clr_adstb_code", 16'd3); expect_v("clr_adstb_valid", 16'd1);
    check(16'(ERR_FLAGS)); check(16'(ERR_CODE)); check(16'(ERR_VALID));

    // Saturation on ch3
    do_reset;
    expect_v("sat_ch3", 16'd15);
    repeat (17) svc(4'b1000, 4'b1000, 0);
    check(cnt(3));

    // Reset in the middle of XFER, with errors and counts pending
    bus.DREQ = 4'b0001; bus.HRQ = 1'b1; tick;
    bus.HLDA = 1'b1; tick;
    bus.AEN = 1'b1; bus.DACK = 4'b0010; tick;
    bus.MEMR_N = 1'b0; tick;
    expect_v("pre_rst_state", 16'd3); expect_v("pre_rst_flags", 16'h40);
    check(16'(MON_STATE)); check(16'(ERR_FLAGS));
    RESET = 1'b1; tick;
    expect_v("mid_rst_flags", 16'h00); expect_v("mid_rst_valid", 16'd0); expect_v("mid_rst_code", 16'd0);
    expect_v("mid_rst_count", 16'h0);  expect_v("mid_rst_state", 16'd0);
    check(16'(ERR_FLAGS)); check(16'(ERR_VALID)); check(16'(ERR_CODE));
    check(XFER_COUNT); check(16'(MON_STATE));
    RESET = 1'b0; idle_bus; tick;

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d expectations never compared, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
